sprite_multi_display: RTL and testbench
=======================================

SPRITE_MULTI_DISPLAY -- requirements
Module: sprite_multi_display

Interface
REQ-001 The block SHALL have parameter SUB_COMP_ID, default 6'd14, the sub-component code this block accepts.
REQ-002 The block SHALL have parameter CHILD_NUM, default 4, the number of sprite instances (1..8).
REQ-003 The block SHALL have parameter PATTERN_NUM, default 2, the number of pattern-table entries (1..32).
REQ-004 The block SHALL have parameter ADDR_LIMIT, default 768, the pixel memory depth in pixels.
REQ-005 The block SHALL have parameter BPP, default 2, the bits per pixel (palette size 2^BPP).
REQ-006 The block SHALL have parameter TRANSP_IDX, default 0, the palette index treated as transparent.
REQ-007 The block SHALL have parameter BG_COLOR, default 24'h9290ff, the colour used when no child hits.
REQ-008 The block SHALL have port clk, input, 1 bit, the only clock.
REQ-009 The block SHALL have port reset, input, 1 bit, the synchronous active-high reset.
REQ-010 The block SHALL have port writedata, input, 32 bits, the command word.
REQ-011 The block SHALL have ports hcount and vcount, input, 10 bits each, the current pixel position.
REQ-012 The block SHALL have port RGB_output, output, 24 bits, the pixel colour.
REQ-013 The block SHALL have port RGB_valid, output, 1 bit, high when a visible child pixel is on RGB_output.

Function
REQ-014 The command fields SHALL be decoded as follows: sub_comp [31:26], child [25:21], info [20:17], type [16:14], bank [13], msg [12:0].
REQ-015 Bank storage:
- Two banks of per-child state SHALL exist.
- Each child's state SHALL hold: visible, hflip, pattern {base 16b, width 16b, height 16b}, x 10b, y 10b, shift 10b.
REQ-016 A normal write (info==4'b0001, sub_comp==SUB_COMP_ID, child<CHILD_NUM) SHALL update bank[bank].child[child] on the next clk edge:
- type 001: visible=msg[12], hflip=msg[11], and pattern=table[msg[4:0]] only if msg[4:0]<PATTERN_NUM.
- type 010: x=msg[9:0].
- type 011: y=msg[9:0].
- type 100: shift=msg[9:0].
- Other type values SHALL be ignored.
REQ-017 A write with child>=CHILD_NUM, or with a non-matching sub_comp, SHALL be ignored.
REQ-018 A swap command (info==4'b1111) SHALL:
- set pending=1 and pending_bank=bank;
- on the same edge, clear visible for every child in bank ~bank.
REQ-019 Deferred swap:
- While pending=1 and the block sees hcount==0 && vcount==0, active SHALL be set to pending_bank and pending cleared on that edge.
- A new swap command arriving while a swap is pending SHALL overwrite pending_bank.
REQ-020 If a swap command and the frame-origin condition occur in the same cycle, the new bank SHALL be applied immediately and pending SHALL stay 0.
REQ-021 Stage 1 (registered) SHALL evaluate every child c of the active bank:
- dx = hcount - x and dy = vcount - y, computed 10-bit unsigned.
- hit = visible && dx<width && dy<height.
- col = hflip ? width-1-dx : dx.
- addr = base + shift + dy*width + col, 16-bit wrap-around.
REQ-022 Stage 2 (registered) SHALL:
- read a pixel index for each hit child, using index TRANSP_IDX when addr>=ADDR_LIMIT;
- select the lowest-numbered child with hit && index!=TRANSP_IDX;
- drive RGB_output = palette[index] and RGB_valid=1 for that child.
REQ-023 When no child qualifies in Stage 2, RGB_output SHALL be BG_COLOR and RGB_valid=0.
REQ-024 Latency from hcount/vcount to RGB_output SHALL be exactly 2 cycles, with throughput one pixel per cycle.
REQ-025 Bank selection SHALL be sampled in Stage 1, so a swap affects output 2 cycles after the swapping edge.
REQ-026 The pixel memory and palette SHALL be initialised from files at elaboration and are read-only.
REQ-027 Pixels SHALL be packed so that 32/BPP pixels occupy one 32-bit word, with the lowest pixel at the LSBs.

Reset
REQ-028 On reset the block SHALL clear:
- all visible bits in both banks, and all other state fields to 0;
- active, pending, and pending_bank to 0;
- both pipeline stages.
REQ-029 During reset and on the cycle after, RGB_output SHALL be BG_COLOR and RGB_valid 0.
REQ-030 Reset asserted mid-frame SHALL abandon any pending swap.
REQ-031 Writes presented in a cycle with reset=1 SHALL be ignored.

Verification
REQ-032 Scenario single sprite:
- Stimulus: bank0 child0 visible, pattern 0 {0,32,24}, x=100, y=50; swap to bank0, then frame origin.
- Response: hcount=100, vcount=50 gives palette[mem pixel 0] two cycles later; hcount=132 gives BG_COLOR.
REQ-033 Scenario hflip:
- Stimulus: same setup with hflip=1.
- Response: hcount=100 outputs pixel index 31 of row 0.
REQ-034 Scenario priority and transparency:
- Stimulus: children 0 and 1 overlap.
- Response: child 0's colour wins; where child 0's index==TRANSP_IDX, child 1's colour shows.
REQ-035 Scenario deferred swap:
- Stimulus: swap to bank1 at hcount=200, vcount=10.
- Response: output keeps bank0 until frame origin, then follows bank1; bank0 visible bits read 0 afterwards.
REQ-036 Scenario bounds:
- Stimulus: write with child=CHILD_NUM, with pattern code >=PATTERN_NUM, and with a wrong sub_comp.
- Response: state is unchanged in each case.
REQ-037 Scenario reset:
- Stimulus: assert reset with a swap pending and a sprite visible.
- Response: next cycles give BG_COLOR and RGB_valid=0; the frame origin causes no swap.

Source files
------------

// File: rtl/sprite_multi_display.sv
// sprite_multi_display: double-banked sprite compositor with deferred bank swap.
// Two-stage pixel pipeline over a packed pixel ROM and a palette ROM.
module sprite_multi_display #(
    parameter logic [5:0]  SUB_COMP_ID = 6'd14,
    parameter int          CHILD_NUM   = 4,
    parameter int          PATTERN_NUM = 2,
    parameter int          ADDR_LIMIT  = 768,
    parameter int          BPP         = 2,
    parameter int          TRANSP_IDX  = 0,
    parameter logic [23:0] BG_COLOR    = 24'h9290ff
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] writedata,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [23:0] RGB_output,
    output logic        RGB_valid
);
    localparam int PPW     = 32 / BPP;
    localparam int PPW_LOG = $clog2(PPW);
    localparam int WORDS   = (ADDR_LIMIT + PPW - 1) / PPW;
    localparam int AW      = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef struct packed {
        logic        vis;
        logic        hflip;
        logic [15:0] base;
        logic [15:0] wid;
        logic [15:0] hgt;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [9:0]  shift;
    } child_t;

    // Elaboration-time ROM images: pixel index pattern, palette and pattern table.
    function automatic logic [BPP-1:0] pix_init(input int a);
        return BPP'((a * 3 + 1 + (a >>> 5)) % (1 << BPP));
    endfunction

    function automatic logic [31:0] rom_word(input int w);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < PPW; k++) v[k*BPP +: BPP] = pix_init(w * PPW + k);
        return v;
    endfunction

    function automatic logic [23:0] pal(input int i);
        return {8'(i * 37), 8'(i * 91), 8'(i * 143)};
    endfunction

    function automatic logic [47:0] pat_entry(input int n);
        if (n == 0) return {16'd0, 16'd32, 16'd24};
        return {16'(n * 256), 16'd16, 16'd16};
    endfunction

    logic [31:0] w_rom [WORDS];
    logic [23:0] w_pal [1 << BPP];

    for (genvar g = 0; g < WORDS; g++) begin : g_rom
        assign w_rom[g] = rom_word(g);
    end
    for (genvar p = 0; p < (1 << BPP); p++) begin : g_pal
        assign w_pal[p] = pal(p);
    end

    logic [5:0]  w_sub;
    logic [4:0]  w_child;
    logic [3:0]  w_info;
    logic [2:0]  w_type;
    logic        w_bank;
    logic        w_nbank;
    logic [12:0] w_msg;
    logic        w_wr;
    logic        w_swap;
    logic        w_origin;

    assign {w_sub, w_child, w_info, w_type, w_bank, w_msg} = writedata;
    assign w_nbank  = ~w_bank;
    assign w_wr     = (w_sub == SUB_COMP_ID) && (w_info == 4'b0001);
    assign w_swap   = (w_sub == SUB_COMP_ID) && (w_info == 4'b1111);
    assign w_origin = (hcount == 10'd0) && (vcount == 10'd0);

    child_t r_bank [2][CHILD_NUM];
    logic   r_active;
    logic   r_pend;
    logic   r_pend_bank;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < CHILD_NUM; c++)
                    r_bank[b][c] <= '0;
            r_active    <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_bank <= 1'b0;
        end else begin
            for (int c = 0; c < CHILD_NUM; c++) begin
                if (w_wr && int'(w_child) == c) begin
                    case (w_type)
                        3'b001: begin
                            r_bank[w_bank][c].vis   <= w_msg[12];
                            r_bank[w_bank][c].hflip <= w_msg[11];
                            if (int'(w_msg[4:0]) < PATTERN_NUM)
                                {r_bank[w_bank][c].base, r_bank[w_bank][c].wid,
                                 r_bank[w_bank][c].hgt} <= pat_entry(int'(w_msg[4:0]));
                        end
                        3'b010:  r_bank[w_bank][c].x     <= w_msg[9:0];
                        3'b011:  r_bank[w_bank][c].y     <= w_msg[9:0];
                        3'b100:  r_bank[w_bank][c].shift <= w_msg[9:0];
                        default: ;
                    endcase
                end
                // The bank being handed back for redraw starts out empty.
                if (w_swap) r_bank[w_nbank][c].vis <= 1'b0;
            end
            if (w_swap && w_origin) begin
                r_active    <= w_bank;
                r_pend      <= 1'b0;
                r_pend_bank <= w_bank;
            end else if (w_swap) begin
                r_pend      <= 1'b1;
                r_pend_bank <= w_bank;
            end else if (r_pend && w_origin) begin
                r_active <= r_pend_bank;
                r_pend   <= 1'b0;
            end
        end
    end

    logic [CHILD_NUM-1:0] w_hit;
    logic [15:0]          w_addr [CHILD_NUM];
    logic [CHILD_NUM-1:0] r_s1_hit;
    logic [15:0]          r_s1_addr [CHILD_NUM];
    logic [BPP-1:0]       w_idx [CHILD_NUM];
    logic [CHILD_NUM-1:0] w_ok;

    for (genvar c = 0; c < CHILD_NUM; c++) begin : g_child
        child_t      w_cs;
        logic [9:0]  w_dx;
        logic [9:0]  w_dy;
        logic [15:0] w_col;
        logic [31:0] w_word;

        assign w_cs     = r_bank[r_active][c];
        assign w_dx     = hcount - w_cs.x;
        assign w_dy     = vcount - w_cs.y;
        assign w_hit[c] = w_cs.vis && ({6'd0, w_dx} < w_cs.wid)
                          && ({6'd0, w_dy} < w_cs.hgt);
        assign w_col    = w_cs.hflip ? (w_cs.wid - 16'd1 - {6'd0, w_dx}) : {6'd0, w_dx};
        assign w_addr[c] = w_cs.base + {6'd0, w_cs.shift}
                           + ({6'd0, w_dy} * w_cs.wid) + w_col;

        // Stage 2 pixel fetch; out-of-range addresses read as transparent.
        assign w_word   = w_rom[r_s1_addr[c][PPW_LOG +: AW]];
        assign w_idx[c] = (int'(r_s1_addr[c]) < ADDR_LIMIT)
                          ? w_word[int'(r_s1_addr[c][PPW_LOG-1:0]) * BPP +: BPP]
                          : BPP'(TRANSP_IDX);
        assign w_ok[c]  = r_s1_hit[c] && (w_idx[c] != BPP'(TRANSP_IDX));
    end

    logic           w_sel_ok;
    logic [BPP-1:0] w_sel_idx;

    always_comb begin
        w_sel_ok  = 1'b0;
        w_sel_idx = '0;
        for (int c = CHILD_NUM - 1; c >= 0; c--) begin
            if (w_ok[c]) begin
                w_sel_ok  = 1'b1;
                w_sel_idx = w_idx[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_hit   <= '0;
            for (int c = 0; c < CHILD_NUM; c++) r_s1_addr[c] <= '0;
            RGB_output <= BG_COLOR;
            RGB_valid  <= 1'b0;
        end else begin
            r_s1_hit   <= w_hit;
            for (int c = 0; c < CHILD_NUM; c++) r_s1_addr[c] <= w_addr[c];
            RGB_output <= w_sel_ok ? w_pal[w_sel_idx] : BG_COLOR;
            RGB_valid  <= w_sel_ok;
        end
    end
endmodule

// File: tb/tb_sprite_multi_display.sv
// Directed bench for sprite_multi_display: hand-computed pixels from the ROM pattern
// index(a) = (3a + 1 + (a>>5)) mod 4, palette {i*37, i*91, i*143}.
module tb_sprite_multi_display;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] writedata = '0;
    logic [9:0]  hcount = 10'd5;
    logic [9:0]  vcount = 10'd5;
    logic [23:0] RGB_output;
    logic        RGB_valid;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [23:0] BG = 24'h9290ff;
    localparam logic [23:0] C1 = 24'h255b8f;
    localparam logic [23:0] C2 = 24'h4ab61e;
    localparam logic [23:0] C3 = 24'h6f11ad;

    always #5 clk = ~clk;

    sprite_multi_display dut (
        .clk(clk),
        .reset(reset),
        .writedata(writedata),
        .hcount(hcount),
        .vcount(vcount),
        .RGB_output(RGB_output),
        .RGB_valid(RGB_valid)
    );

    function automatic logic [31:0] cmd(input logic [5:0] sub, input logic [4:0] ch,
                                        input logic [3:0] info, input logic [2:0] ty,
                                        input logic bk, input logic [12:0] msg);
        return {sub, ch, info, ty, bk, msg};
    endfunction

    task automatic step(input logic [9:0] h, input logic [9:0] v, input logic [31:0] wd);
        @(negedge clk);
        hcount = h;
        vcount = v;
        writedata = wd;
    endtask

    task automatic wr(input logic [4:0] ch, input logic [2:0] ty, input logic bk,
                      input logic [12:0] msg);
        step(10'd5, 10'd5, cmd(6'd14, ch, 4'b0001, ty, bk, msg));
    endtask

    task automatic swap(input logic [9:0] h, input logic [9:0] v, input logic bk);
        step(h, v, cmd(6'd14, 5'd0, 4'b1111, 3'd0, bk, 13'd0));
    endtask

    task automatic check(input string tag, input logic ev, input logic [23:0] erg);
        n_chk++;
        assert ({RGB_valid, RGB_output} === {ev, erg}) else begin
            n_fail++;
            $error("FAIL %s: got valid=%0b rgb=%h expected valid=%0b rgb=%h",
                   tag, RGB_valid, RGB_output, ev, erg);
        end
    endtask

    task automatic probe(input logic [9:0] h, input logic [9:0] v, input logic ev,
                         input logic [23:0] erg, input string tag);
        step(h, v, 32'd0);
        step(10'd5, 10'd5, 32'd0);
        @(negedge clk);
        check(tag, ev, erg);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_hold", 1'b0, BG);
        reset = 1'b0;
        @(negedge clk);
        check("rst_after", 1'b0, BG);

        // single sprite: bank0 child0 pattern0 at (100,50)
        wr(5'd0, 3'b001, 1'b0, 13'h1000);
        wr(5'd0, 3'b010, 1'b0, 13'd100);
        wr(5'd0, 3'b011, 1'b0, 13'd50);
        swap(10'd5, 10'd5, 1'b0);
        step(10'd0, 10'd0, 32'd0);
        probe(10'd100, 10'd50, 1'b1, C1, "s1_origin");
        probe(10'd101, 10'd50, 1'b0, BG, "s1_transp");
        probe(10'd103, 10'd51, 1'b1, C3, "s1_row1");
        probe(10'd132, 10'd50, 1'b0, BG, "s1_right");
        probe(10'd99, 10'd50, 1'b0, BG, "s1_left");
        probe(10'd101, 10'd73, 1'b1, C3, "s1_lastrow");
        probe(10'd101, 10'd74, 1'b0, BG, "s1_below");

        // back-to-back pixels, two-cycle latency
        step(10'd100, 10'd50, 32'd0);
        step(10'd103, 10'd51, 32'd0);
        step(10'd132, 10'd50, 32'd0);
        check("pipe0", 1'b1, C1);
        step(10'd5, 10'd5, 32'd0);
        check("pipe1", 1'b1, C3);
        step(10'd5, 10'd5, 32'd0);
        check("pipe2", 1'b0, BG);

        // hflip
        wr(5'd0, 3'b001, 1'b0, 13'h1800);
        probe(10'd100, 10'd50, 1'b1, C2, "hflip_l");
        probe(10'd131, 10'd50, 1'b1, C1, "hflip_r");

        // priority and transparency: child1 overlaps with shift 1
        wr(5'd0, 3'b001, 1'b0, 13'h1000);
        wr(5'd1, 3'b001, 1'b0, 13'h1000);
        wr(5'd1, 3'b010, 1'b0, 13'd100);
        wr(5'd1, 3'b011, 1'b0, 13'd50);
        wr(5'd1, 3'b100, 1'b0, 13'd1);
        probe(10'd100, 10'd50, 1'b1, C1, "prio_c0");
        probe(10'd101, 10'd50, 1'b1, C3, "prio_c1");
        probe(10'd131, 10'd50, 1'b1, C2, "prio_c0b");

        // deferred swap to bank1
        wr(5'd2, 3'b001, 1'b1, 13'h1000);
        wr(5'd2, 3'b010, 1'b1, 13'd300);
        wr(5'd2, 3'b011, 1'b1, 13'd100);
        probe(10'd300, 10'd100, 1'b0, BG, "pre_swap_b1");
        swap(10'd200, 10'd10, 1'b1);
        probe(10'd300, 10'd100, 1'b0, BG, "pend_b1");
        probe(10'd100, 10'd50, 1'b0, BG, "pend_b0_clr");
        step(10'd0, 10'd0, 32'd0);
        probe(10'd300, 10'd100, 1'b1, C1, "post_swap");
        probe(10'd320, 10'd100, 1'b1, C1, "post_swap_dx20");
        probe(10'd100, 10'd50, 1'b0, BG, "post_b0");

        // bounds: bad child, bad pattern code, wrong sub_comp
        step(10'd5, 10'd5, cmd(6'd14, 5'd6, 4'b0001, 3'b001, 1'b1, 13'h0000));
        probe(10'd300, 10'd100, 1'b1, C1, "bnd_child6");
        step(10'd5, 10'd5, cmd(6'd14, 5'd4, 4'b0001, 3'b001, 1'b1, 13'h0000));
        probe(10'd300, 10'd100, 1'b1, C1, "bnd_child4");
        wr(5'd2, 3'b001, 1'b1, 13'h1002);
        probe(10'd320, 10'd100, 1'b1, C1, "bnd_pat");
        step(10'd5, 10'd5, cmd(6'd13, 5'd2, 4'b0001, 3'b010, 1'b1, 13'd0));
        probe(10'd300, 10'd100, 1'b1, C1, "bnd_sub");
        step(10'd5, 10'd5, cmd(6'd13, 5'd0, 4'b1111, 3'd0, 1'b0, 13'd0));
        step(10'd0, 10'd0, 32'd0);
        probe(10'd300, 10'd100, 1'b1, C1, "bnd_sub_swap");

        // reset with a swap pending and a sprite visible
        swap(10'd200, 10'd10, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        hcount = 10'd300;
        vcount = 10'd100;
        writedata = cmd(6'd14, 5'd0, 4'b0001, 3'b001, 1'b0, 13'h1000);
        @(negedge clk);
        check("rst_mid1", 1'b0, BG);
        writedata = 32'd0;
        @(negedge clk);
        check("rst_mid2", 1'b0, BG);
        reset = 1'b0;
        hcount = 10'd5;
        vcount = 10'd5;
        @(negedge clk);
        check("rst_mid_post", 1'b0, BG);
        wr(5'd0, 3'b010, 1'b0, 13'd100);
        wr(5'd0, 3'b011, 1'b0, 13'd50);
        wr(5'd0, 3'b001, 1'b1, 13'h1000);
        wr(5'd0, 3'b010, 1'b1, 13'd100);
        wr(5'd0, 3'b011, 1'b1, 13'd50);
        probe(10'd100, 10'd50, 1'b0, BG, "rst_b0_vis");
        step(10'd0, 10'd0, 32'd0);
        probe(10'd100, 10'd50, 1'b0, BG, "rst_no_swap");

        // swap coinciding with frame origin takes effect at once
        swap(10'd0, 10'd0, 1'b1);
        probe(10'd100, 10'd50, 1'b1, C1, "swap_origin");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
